// File: rtl/axi_mst128_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi_mst128_cmd_pkg
// Purpose  : Shared state encodings and AXI constants for the single-
//            outstanding 128-bit AXI command master.
// Contents : state_e (3-bit FSM encoding), fixed AXI attribute values,
//            response codes, resp_merge() accumulator helper.
// Revision : 1.0 - initial release
// ============================================================================
package axi_mst128_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_RD   = 3'd2,
    ST_AW   = 3'd3,
    ST_WR   = 3'd4,
    ST_BR   = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'b100;
  localparam logic [3:0] CACHE_NONE  = 4'b0000;
  localparam logic [2:0] PROT_NONE   = 3'b000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Keeps the first non-OKAY response seen; later responses are ignored.
  function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] resp);
    return (acc == RESP_OKAY) ? resp : acc;
  endfunction

endpackage : axi_mst128_cmd_pkg
`default_nettype wire

// File: rtl/axi_mst128_cmd.sv
`default_nettype none
// ============================================================================
// Module   : axi_mst128_cmd
// Purpose  : Single-outstanding AXI4 128-bit master. Turns a command plus
//            write-data stream into AXI read/write INCR bursts, forwards read
//            beats on a stream, reports per-burst status and a sticky
//            protocol-error flag.
// Ports    : pll_core_cpuclk / pad_cpu_rst_b (async, active-low)
//            cmd_*   : command handshake (write, addr, len=beats-1, id)
//            wdat_*  : write-data stream in
//            rdat_*  : read-data stream out (pass-through of R channel)
//            done_*  : one-cycle completion pulse + first non-OKAY resp
//            proto_err : sticky slave protocol-violation flag
//            ar/aw/w/r/b *_m1 : AXI master bundle
// Revision : 1.0 - initial release
// ============================================================================
module axi_mst128_cmd
  import axi_mst128_cmd_pkg::*;
#(
  parameter int SV48_CONFIG = 0,
  parameter int ID_W        = 8,
  localparam int AW         = 40 + SV48_CONFIG
) (
  input  logic            pll_core_cpuclk,
  input  logic            pad_cpu_rst_b,
  // command
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [ID_W-1:0] cmd_id,
  // write-data stream
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [127:0]    wdat_data,
  input  logic [15:0]     wdat_strb,
  // read-data stream
  output logic            rdat_valid,
  input  logic            rdat_ready,
  output logic [127:0]    rdat_data,
  output logic            rdat_last,
  output logic [1:0]      rdat_resp,
  // status
  output logic            done_valid,
  output logic [1:0]      done_resp,
  output logic            proto_err,
  // AXI AR
  output logic            arvalid_m1,
  input  logic            arready_m1,
  output logic [AW-1:0]   araddr_m1,
  output logic [ID_W-1:0] arid_m1,
  output logic [7:0]      arlen_m1,
  output logic [2:0]      arsize_m1,
  output logic [1:0]      arburst_m1,
  output logic [3:0]      arcache_m1,
  output logic [2:0]      arprot_m1,
  // AXI AW
  output logic            awvalid_m1,
  input  logic            awready_m1,
  output logic [AW-1:0]   awaddr_m1,
  output logic [ID_W-1:0] awid_m1,
  output logic [7:0]      awlen_m1,
  output logic [2:0]      awsize_m1,
  output logic [1:0]      awburst_m1,
  output logic [3:0]      awcache_m1,
  output logic [2:0]      awprot_m1,
  // AXI W
  output logic            wvalid_m1,
  input  logic            wready_m1,
  output logic [127:0]    wdata_m1,
  output logic [15:0]     wstrb_m1,
  output logic [ID_W-1:0] wid_m1,
  output logic            wlast_m1,
  // AXI R
  input  logic            rvalid_m1,
  output logic            rready_m1,
  input  logic [127:0]    rdata_m1,
  input  logic [ID_W-1:0] rid_m1,
  input  logic [1:0]      rresp_m1,
  input  logic            rlast_m1,
  // AXI B
  input  logic            bvalid_m1,
  output logic            bready_m1,
  input  logic [ID_W-1:0] bid_m1,
  input  logic [1:0]      bresp_m1
);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      beat_cnt_q;
  logic [1:0]      done_resp_q;
  logic            done_valid_q;
  logic            proto_err_q;

  logic cmd_hs, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic at_len, r_end, err_d;

  assign cmd_hs = cmd_valid  & cmd_ready;
  assign ar_hs  = arvalid_m1 & arready_m1;
  assign aw_hs  = awvalid_m1 & awready_m1;
  assign r_hs   = rvalid_m1  & rready_m1;
  assign w_hs   = wvalid_m1  & wready_m1;
  assign b_hs   = bvalid_m1  & bready_m1;

  // Compared before the increment, so len=255 needs no 9th counter bit.
  assign at_len = (beat_cnt_q == len_q);
  // A read burst ends on rlast or at beat len, whichever comes first.
  assign r_end  = r_hs & (rlast_m1 | at_len);

  assign err_d = (r_hs & (rid_m1 != id_q))
               | (b_hs & (bid_m1 != id_q))
               | (r_hs &  rlast_m1 & ~at_len)
               | (r_hs & ~rlast_m1 &  at_len)
               | (rvalid_m1 & (state_q != ST_RD))
               | (bvalid_m1 & (state_q != ST_BR));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_hs)        state_d = cmd_write ? ST_AW : ST_AR;
      ST_AR:   if (ar_hs)         state_d = ST_RD;
      ST_RD:   if (r_end)         state_d = ST_IDLE;
      ST_AW:   if (aw_hs)         state_d = ST_WR;
      ST_WR:   if (w_hs & at_len) state_d = ST_BR;
      ST_BR:   if (b_hs)          state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    cmd_ready  = 1'b0;
    arvalid_m1 = 1'b0;
    awvalid_m1 = 1'b0;
    rready_m1  = 1'b0;
    rdat_valid = 1'b0;
    wvalid_m1  = 1'b0;
    wdat_ready = 1'b0;
    wlast_m1   = 1'b0;
    bready_m1  = 1'b0;
    case (state_q)
      // Hold off during the done pulse so bursts never overlap.
      ST_IDLE: cmd_ready  = ~done_valid_q;
      ST_AR:   arvalid_m1 = 1'b1;
      ST_RD: begin
        rready_m1  = rdat_ready;
        rdat_valid = rvalid_m1;
      end
      ST_AW:   awvalid_m1 = 1'b1;
      ST_WR: begin
        wvalid_m1  = wdat_valid;
        wdat_ready = wready_m1;
        wlast_m1   = at_len;
      end
      ST_BR:   bready_m1  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      beat_cnt_q   <= '0;
      done_resp_q  <= RESP_OKAY;
      done_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q      <= cmd_addr;
        len_q       <= cmd_len;
        id_q        <= cmd_id;
        beat_cnt_q  <= '0;
        done_resp_q <= RESP_OKAY;
      end
      if (r_hs | w_hs) beat_cnt_q  <= beat_cnt_q + 8'd1;
      if (r_hs)        done_resp_q <= resp_merge(done_resp_q, rresp_m1);
      if (b_hs)        done_resp_q <= resp_merge(done_resp_q, bresp_m1);
      done_valid_q <= r_end | b_hs;
      proto_err_q  <= proto_err_q | err_d;
    end
  end

  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;
  assign proto_err  = proto_err_q;

  assign araddr_m1  = addr_q;
  assign arid_m1    = id_q;
  assign arlen_m1   = len_q;
  assign arsize_m1  = SIZE_16B;
  assign arburst_m1 = BURST_INCR;
  assign arcache_m1 = CACHE_NONE;
  assign arprot_m1  = PROT_NONE;

  assign awaddr_m1  = addr_q;
  assign awid_m1    = id_q;
  assign awlen_m1   = len_q;
  assign awsize_m1  = SIZE_16B;
  assign awburst_m1 = BURST_INCR;
  assign awcache_m1 = CACHE_NONE;
  assign awprot_m1  = PROT_NONE;

  assign wdata_m1   = wdat_data;
  assign wstrb_m1   = wdat_strb;
  assign wid_m1     = id_q;

  assign rdat_data  = rdata_m1;
  assign rdat_last  = rlast_m1;
  assign rdat_resp  = rresp_m1;

endmodule : axi_mst128_cmd
`default_nettype wire

// File: tb/tb_axi_mst128_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mst128_cmd
// Purpose  : Directed testbench for axi_mst128_cmd. Stimulus tasks play both
//            the command source and the AXI slave; expected beats, address
//            phases and completions are queued and a negedge monitor pops and
//            compares them as the DUT presents handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mst128_cmd;
  import axi_mst128_cmd_pkg::*;

  localparam int AW   = 40;
  localparam int ID_W = 8;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [ID_W-1:0] cmd_id;
  logic            wdat_valid, wdat_ready;
  logic [127:0]    wdat_data;
  logic [15:0]     wdat_strb;
  logic            rdat_valid, rdat_ready, rdat_last;
  logic [127:0]    rdat_data;
  logic [1:0]      rdat_resp;
  logic            done_valid, proto_err;
  logic [1:0]      done_resp;
  logic            arvalid, arready, awvalid, awready;
  logic [AW-1:0]   araddr, awaddr;
  logic [ID_W-1:0] arid, awid, wid, rid, bid;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, rresp, bresp;
  logic [3:0]      arcache, awcache;
  logic            wvalid, wready, wlast, rvalid, rready, rlast, bvalid, bready;
  logic [127:0]    wdata, rdata;
  logic [15:0]     wstrb;

  always #5 clk = ~clk;

  axi_mst128_cmd #(.SV48_CONFIG(0), .ID_W(ID_W)) dut (
    .pll_core_cpuclk(clk),      .pad_cpu_rst_b(rst_b),
    .cmd_valid(cmd_valid),      .cmd_ready(cmd_ready),     .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),        .cmd_len(cmd_len),         .cmd_id(cmd_id),
    .wdat_valid(wdat_valid),    .wdat_ready(wdat_ready),
    .wdat_data(wdat_data),      .wdat_strb(wdat_strb),
    .rdat_valid(rdat_valid),    .rdat_ready(rdat_ready),   .rdat_data(rdat_data),
    .rdat_last(rdat_last),      .rdat_resp(rdat_resp),
    .done_valid(done_valid),    .done_resp(done_resp),     .proto_err(proto_err),
    .arvalid_m1(arvalid),       .arready_m1(arready),      .araddr_m1(araddr),
    .arid_m1(arid),             .arlen_m1(arlen),          .arsize_m1(arsize),
    .arburst_m1(arburst),       .arcache_m1(arcache),      .arprot_m1(arprot),
    .awvalid_m1(awvalid),       .awready_m1(awready),      .awaddr_m1(awaddr),
    .awid_m1(awid),             .awlen_m1(awlen),          .awsize_m1(awsize),
    .awburst_m1(awburst),       .awcache_m1(awcache),      .awprot_m1(awprot),
    .wvalid_m1(wvalid),         .wready_m1(wready),        .wdata_m1(wdata),
    .wstrb_m1(wstrb),           .wid_m1(wid),              .wlast_m1(wlast),
    .rvalid_m1(rvalid),         .rready_m1(rready),        .rdata_m1(rdata),
    .rid_m1(rid),               .rresp_m1(rresp),          .rlast_m1(rlast),
    .bvalid_m1(bvalid),         .bready_m1(bready),        .bid_m1(bid),
    .bresp_m1(bresp)
  );

  // ------------------------------------------------------------ scoreboard
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [ID_W-1:0] id; } aphase_t;
  typedef struct { logic [127:0] data; logic last; logic [1:0] resp; } rbeat_t;
  typedef struct { logic [127:0] data; logic [15:0] strb; logic last; logic [ID_W-1:0] id; } wbeat_t;
  typedef struct { string nm; logic [127:0] act; logic [127:0] exp; } post_t;

  aphase_t    exp_ar[$];
  aphase_t    exp_aw[$];
  rbeat_t     exp_r[$];
  wbeat_t     exp_w[$];
  logic [1:0] exp_done[$];
  post_t      post_q[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  logic aw_seen = 1'b0;

  // Stimulus side: record a sampled value against its expectation.
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    post_t p;
    p.nm = nm; p.act = act; p.exp = exp;
    post_q.push_back(p);
  endtask

  // Monitor side: the only place the counters change.
  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got an unexpected handshake, required none queued (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin : monitor
    aphase_t a;
    rbeat_t  r;
    wbeat_t  w;
    post_t   p;
    while (post_q.size() > 0) begin
      p = post_q.pop_front();
      cmp(p.nm, p.act, p.exp);
    end
    if (rst_b) begin
      if (cmd_valid && cmd_ready) aw_seen = 1'b0;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) miss("ar_unexpected");
        else begin
          a = exp_ar.pop_front();
          cmp("araddr", araddr, a.addr);
          cmp("arlen", arlen, a.len);
          cmp("arid", arid, a.id);
          cmp("arsize", arsize, SIZE_16B);
          cmp("arburst", arburst, BURST_INCR);
          cmp("arcache_prot", {arcache, arprot}, 7'd0);
        end
      end
      if (awvalid && awready) begin
        aw_seen = 1'b1;
        if (exp_aw.size() == 0) miss("aw_unexpected");
        else begin
          a = exp_aw.pop_front();
          cmp("awaddr", awaddr, a.addr);
          cmp("awlen", awlen, a.len);
          cmp("awid", awid, a.id);
          cmp("awsize", awsize, SIZE_16B);
          cmp("awburst", awburst, BURST_INCR);
          cmp("awcache_prot", {awcache, awprot}, 7'd0);
        end
      end
      if (wvalid) cmp("wvalid_after_aw", aw_seen, 1'b1);
      if (wvalid && wready) begin
        if (exp_w.size() == 0) miss("w_unexpected");
        else begin
          w = exp_w.pop_front();
          cmp("wdata", wdata, w.data);
          cmp("wstrb", wstrb, w.strb);
          cmp("wlast", wlast, w.last);
          cmp("wid", wid, w.id);
        end
      end
      if (rdat_valid && rdat_ready) begin
        if (exp_r.size() == 0) miss("rdat_unexpected");
        else begin
          r = exp_r.pop_front();
          cmp("rdat_data", rdat_data, r.data);
          cmp("rdat_last", rdat_last, r.last);
          cmp("rdat_resp", rdat_resp, r.resp);
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) miss("done_unexpected");
        else cmp("done_resp", done_resp, exp_done.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  function automatic logic sig(input int sel);
    case (sel)
      0: return arvalid;
      1: return awvalid;
      2: return rready;
      3: return wdat_ready;
      4: return bready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string nm);
    int k = 0;
    while (!sig(sel) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sig(sel)) chk(nm, sig(sel), 1'b1);
  endtask

  function automatic logic [127:0] wd(input int i);
    return {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'(i)};
  endfunction

  task automatic cmd_issue(input logic wr, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [ID_W-1:0] id);
    int k = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    while (!cmd_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Slave sends nsend beats with resp; rlast on beat last_at (-1 = never).
  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] l, input logic [ID_W-1:0] id,
                         input logic [1:0] resp, input int nsend, input int last_at,
                         input logic [1:0] exp_dresp);
    aphase_t ap;
    rbeat_t  rb;
    ap.addr = a; ap.len = l; ap.id = id;
    exp_ar.push_back(ap);
    exp_done.push_back(exp_dresp);
    cmd_issue(1'b0, a, l, id);
    chk("arvalid_latency", arvalid, 1'b1);
    wait_for(0, "arvalid_timeout");
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      rb.data = (resp == RESP_OKAY) ? {a[31:0], 32'(i), 32'hDEAD_BEEF, ~a[31:0]} : 128'd0;
      rb.last = (i == last_at);
      rb.resp = resp;
      exp_r.push_back(rb);
      rvalid = 1'b1; rdata = rb.data; rid = id; rresp = resp; rlast = rb.last;
      wait_for(2, "rready_timeout");
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("rd_done_pulse", done_valid, 1'b1);
    @(posedge clk); #1;
    chk("rd_done_single", done_valid, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] l, input logic [ID_W-1:0] id,
                          input logic [1:0] br, input int aw_delay, input logic early,
                          input int rst_beat);
    aphase_t ap;
    wbeat_t  wb;
    ap.addr = a; ap.len = l; ap.id = id;
    exp_aw.push_back(ap);
    exp_done.push_back(br);
    for (int i = 0; i <= int'(l); i++) begin
      wb.data = wd(i); wb.strb = 16'hFFFF; wb.last = (i == int'(l)); wb.id = id;
      exp_w.push_back(wb);
    end
    wready = 1'b1;
    cmd_issue(1'b1, a, l, id);
    chk("awvalid_latency", awvalid, 1'b1);
    if (early) begin
      wdat_valid = 1'b1; wdat_data = wd(0); wdat_strb = 16'hFFFF;
    end
    for (int k = 0; k < aw_delay; k++) begin
      chk("wvalid_pre_aw", wvalid, 1'b0);
      chk("wdat_ready_pre_aw", wdat_ready, 1'b0);
      @(posedge clk); #1;
    end
    wait_for(1, "awvalid_timeout");
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      wdat_valid = 1'b1; wdat_data = wd(i); wdat_strb = 16'hFFFF;
      if (i == rst_beat) begin
        #2 rst_b = 1'b0;
        #1;
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_wdat_ready", wdat_ready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        exp_w.delete(); exp_done.delete(); exp_aw.delete();
        wdat_valid = 1'b0; wready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_proto_err", proto_err, 1'b0);
        chk("post_rst_done_resp", done_resp, RESP_OKAY);
        chk("post_rst_latched", {awaddr, awlen, awid}, '0);
        @(posedge clk); #1;
        chk("post_rst_no_done", done_valid, 1'b0);
        return;
      end
      wait_for(3, "wdat_ready_timeout");
      @(posedge clk); #1;
    end
    wdat_valid = 1'b0; wready = 1'b0;
    wait_for(4, "bready_timeout");
    bvalid = 1'b1; bid = id; bresp = br;
    @(posedge clk); #1;
    bvalid = 1'b0;
    chk("wr_done_pulse", done_valid, 1'b1);
    @(posedge clk); #1;
    chk("wr_done_single", done_valid, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wdat_valid = 0; wdat_data = '0; wdat_strb = '0; rdat_ready = 1'b1;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 0;
    bvalid = 0; bid = '0; bresp = '0;

    #3;
    chk("reset_valids", {arvalid, awvalid, wvalid, rdat_valid, bready, done_valid}, 6'b0);
    chk("reset_done_resp", done_resp, RESP_OKAY);
    chk("reset_proto_err", proto_err, 1'b0);
    chk("reset_latched", {araddr, arlen, arid}, '0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // single-beat OKAY read
    do_read(40'h10_0000_1000, 8'd0, 8'h11, RESP_OKAY, 1, 0, RESP_OKAY);
    chk("t1_proto_err", proto_err, 1'b0);
    // 4-beat OKAY write
    do_write(40'h00_0000_2000, 8'd3, 8'h22, RESP_OKAY, 0, 1'b0, -1);
    // 4-beat read from error responder
    do_read(40'h00_0000_3000, 8'd3, 8'h33, RESP_SLVERR, 4, 3, RESP_SLVERR);
    chk("done_resp_hold", done_resp, RESP_SLVERR);
    // write with slow awready, early write data, SLVERR response
    do_write(40'h00_0000_4000, 8'd1, 8'h44, RESP_SLVERR, 5, 1'b1, -1);
    chk("t4_proto_err", proto_err, 1'b0);
    // early rlast on beat 1 of a len=3 read
    do_read(40'h00_0000_5000, 8'd3, 8'h55, RESP_OKAY, 2, 1, RESP_OKAY);
    chk("early_rlast_proto_err", proto_err, 1'b1);
    // clean 256-beat read, flag stays sticky
    do_read(40'h00_0001_0000, 8'd255, 8'h66, RESP_OKAY, 256, 255, RESP_OKAY);
    chk("sticky_after_read", proto_err, 1'b1);
    do_write(40'h00_0000_7000, 8'd0, 8'h77, RESP_OKAY, 0, 1'b1, -1);
    chk("sticky_after_write", proto_err, 1'b1);
    // reset pulse during write beat 2
    do_write(40'h00_0000_8000, 8'd3, 8'h88, RESP_OKAY, 0, 1'b0, 2);
    // missing rlast at beat len still completes, flags error
    do_read(40'h00_0000_9000, 8'd1, 8'h99, RESP_DECERR, 2, -1, RESP_DECERR);
    chk("no_rlast_proto_err", proto_err, 1'b1);

    chk("drain_ar", exp_ar.size(), 0);
    chk("drain_aw", exp_aw.size(), 0);
    chk("drain_r", exp_r.size(), 0);
    chk("drain_w", exp_w.size(), 0);
    chk("drain_done", exp_done.size(), 0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_axi_mst128_cmd
`default_nettype wire

// File: doc/axi_mst128_cmd.md
Name: axi_mst128_cmd

Overview:
- Single-outstanding AXI4 128-bit master (initiator). Converts a simple command/data-stream interface into AXI read and write bursts.
- Sits in the C908 test environment opposite slave-side models such as the 128-bit error/memory responders. Drives their _s1 ports through its _m1 ports.
- Reports per-burst completion status and a sticky protocol-error flag.

Parameters:
- SV48_CONFIG, 0, extra address bits; address width AW = 40+SV48_CONFIG.
- ID_W, 8, width of arid/awid/wid/rid/bid.

Ports:
- pll_core_cpuclk  in  1  clock
- pad_cpu_rst_b  in  1  reset
- cmd_valid / cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  burst start address (16-byte aligned)
- cmd_len  in  8  beats-1
- cmd_id  in  ID_W  transaction id
- wdat_valid / wdat_ready  in/out  1/1  write-data stream handshake
- wdat_data / wdat_strb  in  128/16  write beat data / byte strobes
- rdat_valid / rdat_ready  out/in  1/1  read-data stream handshake
- rdat_data / rdat_last / rdat_resp  out  128/1/2  read beat data, last flag, response
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  first non-OKAY resp of the burst, else 2'b00
- proto_err  out  1  sticky protocol-violation flag
- AXI master bundle (all _m1): ar{valid,ready,addr,id,len,size,burst,cache,prot}, aw{same}, w{valid,ready,data,strb,id,last}, r{valid,ready,data,id,resp,last}, b{valid,ready,id,resp}. Widths match the _s1 slave ports; addr is AW bits.

Behaviour:
- Reset: pad_cpu_rst_b is asynchronous, active-low. Clock is pll_core_cpuclk.
- During reset, all valid outputs = 0 and done_resp = 0, proto_err = 0, state = IDLE. Latched addr/len/id = 0.
- Reset asserted mid-burst aborts immediately. No completion pulse is generated.
- Fixed AXI attributes: size=3'b100, burst=2'b01 (INCR), cache=4'b0, prot=3'b0.
- States: IDLE, AR, RD, AW, WR, BR.
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_*, clear beat_cnt and the resp accumulator, then go to AR (read) or AW (write).
  - AR: arvalid=1 from latched registers, held stable until arready, then RD. Command-to-arvalid latency = 1 cycle.
  - RD: rready_m1=rdat_ready. rdat_* is a combinational pass-through of r*. beat_cnt increments on each r handshake.
    - On a handshake with rlast: done_valid=1 next cycle, then IDLE.
  - AW: awvalid=1 until awready, then WR. wvalid must never rise before the AW handshake.
  - WR: wvalid_m1=wdat_valid and wdat_ready=wready_m1. wlast=(beat_cnt==len). wid=latched id.
    - After the last-beat handshake, go to BR.
  - BR: bready=1. On bvalid, capture bresp, pulse done_valid, then IDLE.
- done_resp: updated on the first beat or b whose resp != 2'b00, then frozen until the next command. It is valid with done_valid and holds until the next command.
- proto_err sets and stays set until reset on any of:
  - rid or bid != latched id.
  - rlast on a beat with beat_cnt != len. Burst still terminates on rlast.
  - No rlast when beat_cnt == len. Burst still completes at beat len.
  - rvalid/bvalid outside RD/BR.
- beat_cnt is 8-bit. len=255 gives 256 beats with no wrap issue, since compare happens before increment.
- Back-to-back: a new command is accepted in the cycle after done_valid (IDLE). No overlap.

Decomposition:
- Shared package holds:
  - State encodings (3-bit).
  - AXI constants: BURST_INCR=2'b01, SIZE_16B=3'b100, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- No sub-module is needed. A single FSM plus counter and resp accumulator fits about 250 lines.

Test Plan:
- Read, len=0, addr=0x1000, against an OKAY memory model -> arlen=0, arsize=4, arburst=1, one rdat beat with rdat_last=1, done_resp=00, proto_err=0.
- Write, len=3, 4 wdat beats with strb=16'hFFFF -> wlast only on the 4th beat, then bready. done_valid 1 cycle after the b handshake, done_resp=00.
- Read, len=3, against the error responder -> 4 beats with rdat_resp=2'b10, rdata=0, done_resp=2'b10.
- Write with awready delayed 5 cycles and wdat_valid available early -> wvalid stays low until the AW handshake. bid=cmd_id, done_resp=2'b10 from the error slave.
- Slave drives rlast on beat 1 of a len=3 read -> burst ends, done_valid pulses, proto_err=1 and stays 1 across later clean bursts.
- pad_cpu_rst_b pulsed during WR beat 2 -> all valids 0 asynchronously, no done_valid, cmd_ready=1 after release.
